// File: rtl/spi_reg_ctrl.sv
// Frame-level command controller for the SPI slave engine: decodes command/data
// frames into register-bank writes and reads, and supplies the next transmit byte.
module spi_reg_ctrl #(
  parameter int unsigned NREGS       = 8,
  parameter logic [7:0]  STATUS_BYTE = 8'h10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss,
  input  logic                 byte_done,
  input  logic [7:0]           rx_byte,
  output logic [7:0]           tx_byte,
  output logic [NREGS*8-1:0]   regs,
  output logic                 wr_strobe,
  output logic [3:0]           wr_addr,
  output logic                 busy,
  output logic [7:0]           err_count
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned GW = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMD   = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic          ss_meta_q, ss_meta_d;
  logic          ss_s_q, ss_s_d;
  logic          ss_s_dly_q, ss_s_dly_d;
  logic [GW-1:0] guard_q, guard_d;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] tx_byte_q, tx_byte_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] err_count_q, err_count_d;
  logic [DW-1:0] reg_q [NREGS];
  logic [DW-1:0] reg_d [NREGS];

  logic frame_start_c;
  logic frame_end_c;
  logic err_inc_c;

  function automatic logic is_mapped(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(NREGS);
  endfunction

  function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (a == AW'(i)) v = reg_q[i];
    end
    return v;
  endfunction

  // Synchronizer plus a post-reset guard: the synchronizer resets high, so a
  // pad already low at release would otherwise look like a frame start.
  always_comb begin
    ss_meta_d     = ss;
    ss_s_d        = ss_meta_q;
    ss_s_dly_d    = ss_s_q;
    guard_d       = (guard_q == GW'(3)) ? guard_q : guard_q + GW'(1);
    frame_start_c = (guard_q == GW'(3)) && ss_s_dly_q && !ss_s_q;
    frame_end_c   = !ss_s_dly_q && ss_s_q;
  end

  // Frame decode, register update and transmit byte selection.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tx_byte_d   = tx_byte_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_inc_c   = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) reg_d[i] = reg_q[i];

    case (state_q)
      S_IDLE: begin
        if (frame_start_c) begin
          state_d   = S_CMD;
          tx_byte_d = STATUS_BYTE;
        end
      end
      S_CMD: begin
        if (byte_done) begin
          addr_d = rx_byte[AW-1:0];
          if (rx_byte[7]) begin
            state_d = S_WDATA;
          end else begin
            state_d   = S_RDATA;
            tx_byte_d = read_reg(rx_byte[AW-1:0]);
          end
        end else if (frame_end_c) begin
          err_inc_c = 1'b1;
        end
      end
      S_WDATA: begin
        if (byte_done) begin
          if (is_mapped(addr_q)) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
              if (addr_q == AW'(i)) reg_d[i] = rx_byte;
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end else begin
            err_inc_c = 1'b1;
          end
          addr_d = addr_q + AW'(1);
        end
      end
      S_RDATA: begin
        if (byte_done) begin
          // The byte just shifted out came from addr_q.
          if (!is_mapped(addr_q)) err_inc_c = 1'b1;
          addr_d    = addr_q + AW'(1);
          tx_byte_d = read_reg(addr_q + AW'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte completing in the same cycle as frame end is processed above first.
    if ((state_q != S_IDLE) && frame_end_c) begin
      state_d   = S_IDLE;
      tx_byte_d = STATUS_BYTE;
    end

    err_count_d = (err_inc_c && (err_count_q != 8'hFF)) ? err_count_q + DW'(1) : err_count_q;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_meta_q   <= 1'b1;
      ss_s_q      <= 1'b1;
      ss_s_dly_q  <= 1'b1;
      guard_q     <= '0;
      state_q     <= S_IDLE;
      addr_q      <= '0;
      tx_byte_q   <= STATUS_BYTE;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) reg_q[i] <= '0;
    end else begin
      ss_meta_q   <= ss_meta_d;
      ss_s_q      <= ss_s_d;
      ss_s_dly_q  <= ss_s_dly_d;
      guard_q     <= guard_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      tx_byte_q   <= tx_byte_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      busy_q      <= busy_d;
      err_count_q <= err_count_d;
      for (int unsigned i = 0; i < NREGS; i++) reg_q[i] <= reg_d[i];
    end
  end

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_regs
    assign regs[g*8 +: 8] = reg_q[g];
  end

  assign tx_byte   = tx_byte_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = busy_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed plus randomized frames for spi_reg_ctrl, checked against a byte-level
// model of the register bank, address pointer and error counter.
module tb_spi_reg_ctrl;

  localparam int unsigned NREGS  = 8;
  localparam logic [7:0]  STATUS = 8'h10;

  logic               clk = 1'b0;
  logic               rst;
  logic               ss;
  logic               byte_done;
  logic [7:0]         rx_byte;
  logic [7:0]         tx_byte;
  logic [NREGS*8-1:0] regs;
  logic               wr_strobe;
  logic [3:0]         wr_addr;
  logic               busy;
  logic [7:0]         err_count;

  spi_reg_ctrl #(.NREGS(NREGS), .STATUS_BYTE(STATUS)) dut (
    .clk(clk), .rst(rst), .ss(ss), .byte_done(byte_done), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0] mem [16];
  int         m_err;
  bit         m_in_frame;
  bit         m_got_cmd;
  bit         m_write;
  int         m_addr;
  logic [7:0] m_tx;
  logic [3:0] m_wa;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    return (a < int'(NREGS)) ? mem[a] : 8'h00;
  endfunction

  function automatic void m_err_inc();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_err = 0; m_in_frame = 0; m_got_cmd = 0; m_write = 0;
    m_addr = 0; m_tx = STATUS; m_wa = 4'h0;
  endfunction

  // Apply one received byte to the model; returns whether a write strobe is due.
  function automatic bit m_byte(input logic [7:0] b);
    bit st;
    st = 0;
    if (!m_in_frame) return 0;
    if (!m_got_cmd) begin
      m_got_cmd = 1;
      m_write   = b[7];
      m_addr    = int'(b[3:0]);
      if (!m_write) m_tx = m_read(m_addr);
    end else if (m_write) begin
      if (m_addr < int'(NREGS)) begin
        mem[m_addr] = b;
        m_wa = 4'(m_addr);
        st = 1;
      end else begin
        m_err_inc();
      end
      m_addr = (m_addr + 1) % 16;
    end else begin
      if (m_addr >= int'(NREGS)) m_err_inc();
      m_addr = (m_addr + 1) % 16;
      m_tx = m_read(m_addr);
    end
    return st;
  endfunction

  function automatic void m_close();
    if (m_in_frame && !m_got_cmd) m_err_inc();
    m_in_frame = 0;
    m_got_cmd  = 0;
    m_tx       = STATUS;
  endfunction

  task automatic check_bank(input string tag);
    logic [63:0] ev;
    ev = '0;
    for (int i = 0; i < int'(NREGS); i++) ev[i*8 +: 8] = mem[i];
    chk({tag, ".regs"}, 64'(regs), ev);
    chk({tag, ".err"}, 64'(err_count), 64'(m_err));
  endtask

  task automatic frame_open();
    ss = 1'b0;
    tick(3);
    m_in_frame = 1;
    m_got_cmd  = 0;
    m_tx       = STATUS;
    chk("open.busy", 64'(busy), 64'(1));
    chk("open.tx", 64'(tx_byte), 64'(m_tx));
  endtask

  task automatic frame_close();
    ss = 1'b1;
    tick(3);
    m_close();
    chk("close.busy", 64'(busy), 64'(0));
    chk("close.tx", 64'(tx_byte), 64'(m_tx));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit st;
    rx_byte = b;
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    rx_byte = 8'($urandom);
    st = m_byte(b);
    chk("byte.strobe", 64'(wr_strobe), 64'(st));
    chk("byte.wr_addr", 64'(wr_addr), 64'(m_wa));
    chk("byte.tx", 64'(tx_byte), 64'(m_tx));
    tick();
    chk("byte.strobe_off", 64'(wr_strobe), 64'(0));
  endtask

  // Raise ss so that the synchronized rising edge lands with a byte_done.
  task automatic close_with_byte(input logic [7:0] b);
    bit st;
    ss = 1'b1;
    tick(2);
    rx_byte = b;
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
    st = m_byte(b);
    m_close();
    chk("cwb.strobe", 64'(wr_strobe), 64'(st));
    chk("cwb.busy", 64'(busy), 64'(0));
    chk("cwb.tx", 64'(tx_byte), 64'(m_tx));
    tick();
    chk("cwb.strobe_off", 64'(wr_strobe), 64'(0));
  endtask

  initial begin
    rst = 1'b1; ss = 1'b1; byte_done = 1'b0; rx_byte = 8'h00;
    m_reset();
    tick(3);
    rst = 1'b0;
    tick(5);

    // Idle after reset
    chk("rst.tx", 64'(tx_byte), 64'(STATUS));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.strobe", 64'(wr_strobe), 64'(0));
    chk("rst.wr_addr", 64'(wr_addr), 64'(0));
    check_bank("rst");

    // Write 2,3
    frame_open();
    send_byte(8'h82); send_byte(8'hA5); send_byte(8'h3C);
    frame_close();
    check_bank("wr23");
    chk("wr23.r2", 64'(regs[23:16]), 64'(8'hA5));
    chk("wr23.r3", 64'(regs[31:24]), 64'(8'h3C));

    // Read back from 2
    frame_open();
    send_byte(8'h02);
    chk("rd.tx_a5", 64'(tx_byte), 64'(8'hA5));
    send_byte(8'h00);
    chk("rd.tx_3c", 64'(tx_byte), 64'(8'h3C));
    send_byte(8'hFF);
    frame_close();
    check_bank("rd");

    // Write burst from 7 across unmapped 8..15, wrapping to 0
    frame_open();
    send_byte(8'h87);
    send_byte(8'h11);
    for (int i = 0; i < 8; i++) send_byte(8'h22 + 8'(i));
    send_byte(8'h5A);
    frame_close();
    check_bank("burst");
    chk("burst.err", 64'(err_count), 64'(8));
    chk("burst.r0", 64'(regs[7:0]), 64'(8'h5A));

    // Empty frame, then stray byte in idle
    frame_open();
    frame_close();
    check_bank("empty");
    send_byte(8'h81);
    chk("stray.busy", 64'(busy), 64'(0));
    check_bank("stray");

    // Frame end coincident with a data byte
    frame_open();
    send_byte(8'h85); send_byte(8'h44);
    close_with_byte(8'h55);
    check_bank("cwb");

    // Reset in the middle of a write burst with ss held low
    frame_open();
    send_byte(8'h81); send_byte(8'h77);
    rst = 1'b1;
    #1;
    m_reset();
    chk("mrst.busy", 64'(busy), 64'(0));
    chk("mrst.tx", 64'(tx_byte), 64'(STATUS));
    check_bank("mrst");
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("mrst.idle", 64'(busy), 64'(0));
    send_byte(8'h81); send_byte(8'h99);
    chk("mrst.ignored", 64'(busy), 64'(0));
    check_bank("mrst_ign");
    frame_close();
    frame_open();
    send_byte(8'h81); send_byte(8'h66);
    frame_close();
    check_bank("mrst_after");

    // Random frames
    for (int f = 0; f < 60; f++) begin
      int nb;
      logic [7:0] cmd;
      frame_open();
      nb = int'($urandom_range(0, 6));
      cmd = 8'($urandom);
      for (int k = 0; k < nb; k++) send_byte((k == 0) ? cmd : 8'($urandom));
      if ($urandom_range(0, 3) == 0) close_with_byte(8'($urandom));
      else frame_close();
      check_bank("rand");
    end

    // Saturate the error counter with empty frames
    for (int f = 0; f < 260; f++) begin
      ss = 1'b0; tick(3); m_in_frame = 1; m_got_cmd = 0;
      ss = 1'b1; tick(3); m_close();
    end
    chk("sat.err", 64'(err_count), 64'(8'hFF));
    check_bank("sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
